// File: rtl/sm4_pkg.sv
// Shared SM4 constants: FSM encoding, FK/CK tables, S-box table and the
// key-schedule linear transform L'.
package sm4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } sm4_state_e;

    localparam int unsigned SM4_ROUNDS = 32;
    localparam logic [4:0]  LAST_ROUND = 5'(SM4_ROUNDS - 1);

    localparam logic [0:3][31:0] FK = {
        32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
    };

    localparam logic [0:31][31:0] CK = {
        32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
        32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
        32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
        32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
        32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
        32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
        32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
        32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
    };

    localparam logic [0:255][7:0] SBOX = {
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    // Key-schedule diffusion: B ^ (B <<< 13) ^ (B <<< 23).
    function automatic logic [31:0] sm4_l_key(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 8-bit S-box, purely combinational; shared by key schedule and round datapath.
module sm4_sbox
    import sm4_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/sm4_key_expansion.sv
// SM4 key schedule: one round key per cycle into a 32-entry register bank.
// Define SM4_KEY_DEC_ORDER_EN to compile in the decrypt-order output reversal.
module sm4_key_expansion
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         sm4_enable_in,
    input  logic         user_key_valid_in,
    input  logic [127:0] user_key_in,
    input  logic         enc_dec_sel_in,
    output logic         key_exp_ready_out,
    output logic [31:0]  rk_00_out,
    output logic [31:0]  rk_01_out,
    output logic [31:0]  rk_02_out,
    output logic [31:0]  rk_03_out,
    output logic [31:0]  rk_04_out,
    output logic [31:0]  rk_05_out,
    output logic [31:0]  rk_06_out,
    output logic [31:0]  rk_07_out,
    output logic [31:0]  rk_08_out,
    output logic [31:0]  rk_09_out,
    output logic [31:0]  rk_10_out,
    output logic [31:0]  rk_11_out,
    output logic [31:0]  rk_12_out,
    output logic [31:0]  rk_13_out,
    output logic [31:0]  rk_14_out,
    output logic [31:0]  rk_15_out,
    output logic [31:0]  rk_16_out,
    output logic [31:0]  rk_17_out,
    output logic [31:0]  rk_18_out,
    output logic [31:0]  rk_19_out,
    output logic [31:0]  rk_20_out,
    output logic [31:0]  rk_21_out,
    output logic [31:0]  rk_22_out,
    output logic [31:0]  rk_23_out,
    output logic [31:0]  rk_24_out,
    output logic [31:0]  rk_25_out,
    output logic [31:0]  rk_26_out,
    output logic [31:0]  rk_27_out,
    output logic [31:0]  rk_28_out,
    output logic [31:0]  rk_29_out,
    output logic [31:0]  rk_30_out,
    output logic [31:0]  rk_31_out
);

    sm4_state_e  state_q, state_d;
    logic [4:0]  round_q, round_d;
    logic [31:0] k_q  [4];
    logic [31:0] k_d  [4];
    logic [31:0] rk_q [32];
    logic [31:0] rk_d [32];
    logic        ready_q, ready_d;

    logic [31:0] sbox_in_s, sbox_out_s, k_next_s;
    logic        start_s;
    logic [31:0] rk_sel_s [32];

    // tau: four parallel byte substitutions
    assign sbox_in_s = k_q[1] ^ k_q[2] ^ k_q[3] ^ CK[round_q];
    for (genvar b = 0; b < 4; b++) begin : g_tau
        sm4_sbox u_sbox (
            .din  (sbox_in_s[8*b +: 8]),
            .dout (sbox_out_s[8*b +: 8])
        );
    end
    assign k_next_s = k_q[0] ^ sm4_l_key(sbox_out_s);
    assign start_s  = sm4_enable_in & user_key_valid_in;

    // Next-state, round counter, key window and round-key bank update
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        k_d     = k_q;
        rk_d    = rk_q;
        if (!sm4_enable_in) begin
            // enable low wins over everything; keys are retained, not cleared
            state_d = IDLE;
            round_d = 5'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_s) begin
                        state_d = EXPAND;
                        round_d = 5'd0;
                        k_d[0]  = user_key_in[127:96] ^ FK[0];
                        k_d[1]  = user_key_in[95:64]  ^ FK[1];
                        k_d[2]  = user_key_in[63:32]  ^ FK[2];
                        k_d[3]  = user_key_in[31:0]   ^ FK[3];
                    end else begin
                        state_d = state_q;
                    end
                end
                EXPAND: begin
                    k_d[0]        = k_q[1];
                    k_d[1]        = k_q[2];
                    k_d[2]        = k_q[3];
                    k_d[3]        = k_next_s;
                    rk_d[round_q] = k_next_s;
                    round_d       = round_q + 5'd1;
                    if (round_q == LAST_ROUND) begin
                        state_d = DONE;
                    end else begin
                        state_d = EXPAND;
                    end
                end
                default: begin
                    state_d = IDLE;
                    round_d = 5'd0;
                end
            endcase
        end
        ready_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 5'd0;
            ready_q <= 1'b0;
            k_q     <= '{default: 32'h0};
            rk_q    <= '{default: 32'h0};
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            ready_q <= ready_d;
            k_q     <= k_d;
            rk_q    <= rk_d;
        end
    end

`ifdef SM4_KEY_DEC_ORDER_EN
    for (genvar g = 0; g < 32; g++) begin : g_order
        assign rk_sel_s[g] = enc_dec_sel_in ? rk_q[31-g] : rk_q[g];
    end
`else
    logic unused_sel_s;
    assign unused_sel_s = enc_dec_sel_in;
    for (genvar g = 0; g < 32; g++) begin : g_order
        assign rk_sel_s[g] = rk_q[g];
    end
`endif

    assign key_exp_ready_out = ready_q;
    assign rk_00_out = rk_sel_s[0];
    assign rk_01_out = rk_sel_s[1];
    assign rk_02_out = rk_sel_s[2];
    assign rk_03_out = rk_sel_s[3];
    assign rk_04_out = rk_sel_s[4];
    assign rk_05_out = rk_sel_s[5];
    assign rk_06_out = rk_sel_s[6];
    assign rk_07_out = rk_sel_s[7];
    assign rk_08_out = rk_sel_s[8];
    assign rk_09_out = rk_sel_s[9];
    assign rk_10_out = rk_sel_s[10];
    assign rk_11_out = rk_sel_s[11];
    assign rk_12_out = rk_sel_s[12];
    assign rk_13_out = rk_sel_s[13];
    assign rk_14_out = rk_sel_s[14];
    assign rk_15_out = rk_sel_s[15];
    assign rk_16_out = rk_sel_s[16];
    assign rk_17_out = rk_sel_s[17];
    assign rk_18_out = rk_sel_s[18];
    assign rk_19_out = rk_sel_s[19];
    assign rk_20_out = rk_sel_s[20];
    assign rk_21_out = rk_sel_s[21];
    assign rk_22_out = rk_sel_s[22];
    assign rk_23_out = rk_sel_s[23];
    assign rk_24_out = rk_sel_s[24];
    assign rk_25_out = rk_sel_s[25];
    assign rk_26_out = rk_sel_s[26];
    assign rk_27_out = rk_sel_s[27];
    assign rk_28_out = rk_sel_s[28];
    assign rk_29_out = rk_sel_s[29];
    assign rk_30_out = rk_sel_s[30];
    assign rk_31_out = rk_sel_s[31];

endmodule

// File: tb/tb_sm4_key_expansion.sv
// Directed self-checking bench for sm4_key_expansion using the standard SM4 test key.
module tb_sm4_key_expansion;
    import sm4_pkg::*;

    localparam logic [127:0] KEY_A  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [31:0]  RK0_A  = 32'hF12186F9;
    localparam logic [31:0]  RK1_A  = 32'h41662B61;
    localparam logic [31:0]  RK31_A = 32'h9124A012;
    localparam logic [127:0] CT_A   = 128'h681EDF34D206965E86B3E94F536E4246;

    logic         clk = 1'b0;
    logic         reset;
    logic         sm4_enable_in;
    logic         user_key_valid_in;
    logic [127:0] user_key_in;
    logic         enc_dec_sel_in;
    logic         key_exp_ready_out;
    logic [31:0]  rk_w [32];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sm4_key_expansion dut (
        .clk(clk), .reset(reset), .sm4_enable_in(sm4_enable_in),
        .user_key_valid_in(user_key_valid_in), .user_key_in(user_key_in),
        .enc_dec_sel_in(enc_dec_sel_in), .key_exp_ready_out(key_exp_ready_out),
        .rk_00_out(rk_w[0]),   .rk_01_out(rk_w[1]),   .rk_02_out(rk_w[2]),   .rk_03_out(rk_w[3]),
        .rk_04_out(rk_w[4]),   .rk_05_out(rk_w[5]),   .rk_06_out(rk_w[6]),   .rk_07_out(rk_w[7]),
        .rk_08_out(rk_w[8]),   .rk_09_out(rk_w[9]),   .rk_10_out(rk_w[10]),  .rk_11_out(rk_w[11]),
        .rk_12_out(rk_w[12]),  .rk_13_out(rk_w[13]),  .rk_14_out(rk_w[14]),  .rk_15_out(rk_w[15]),
        .rk_16_out(rk_w[16]),  .rk_17_out(rk_w[17]),  .rk_18_out(rk_w[18]),  .rk_19_out(rk_w[19]),
        .rk_20_out(rk_w[20]),  .rk_21_out(rk_w[21]),  .rk_22_out(rk_w[22]),  .rk_23_out(rk_w[23]),
        .rk_24_out(rk_w[24]),  .rk_25_out(rk_w[25]),  .rk_26_out(rk_w[26]),  .rk_27_out(rk_w[27]),
        .rk_28_out(rk_w[28]),  .rk_29_out(rk_w[29]),  .rk_30_out(rk_w[30]),  .rk_31_out(rk_w[31])
    );

    // Round-function transform T of the encryption datapath
    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse valid with a key, then count cycles (accept cycle included) until ready
    task automatic run_expand(input logic [127:0] key, output int lat);
        user_key_in       = key;
        user_key_valid_in = 1'b1;
        lat = 0;
        do begin
            tick();
            user_key_valid_in = 1'b0;
            lat++;
        end while (!key_exp_ready_out && lat < 40);
    endtask

    task automatic check_keys_a(input string tag);
        n_cmp++;
        if (rk_w[0] !== RK0_A) begin
            n_fail++; $display("FAIL %s rk_00: got %08h want %08h", tag, rk_w[0], RK0_A);
        end
        n_cmp++;
        if (rk_w[1] !== RK1_A) begin
            n_fail++; $display("FAIL %s rk_01: got %08h want %08h", tag, rk_w[1], RK1_A);
        end
        n_cmp++;
        if (rk_w[31] !== RK31_A) begin
            n_fail++; $display("FAIL %s rk_31: got %08h want %08h", tag, rk_w[31], RK31_A);
        end
    endtask

    task automatic test_reset();
        int nz;
        reset = 1'b1; sm4_enable_in = 1'b1; user_key_valid_in = 1'b0;
        user_key_in = 128'h0; enc_dec_sel_in = 1'b0;
        tick(); tick();
        nz = 0;
        for (int i = 0; i < 32; i++) if (rk_w[i] !== 32'h0) nz++;
        n_cmp++;
        if (key_exp_ready_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", key_exp_ready_out);
        end
        n_cmp++;
        if (nz !== 0) begin
            n_fail++; $display("FAIL reset_rk: %0d nonzero keys, want 0", nz);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_encrypt();
        int lat;
        run_expand(KEY_A, lat);
        n_cmp++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL enc_latency: got %0d cycles want 33", lat);
        end
        check_keys_a("enc");
    endtask

    task automatic test_dec_order();
        enc_dec_sel_in = 1'b1;
        #1;
`ifdef SM4_KEY_DEC_ORDER_EN
        n_cmp++;
        if (rk_w[0] !== RK31_A) begin
            n_fail++; $display("FAIL dec_rk_00: got %08h want %08h", rk_w[0], RK31_A);
        end
        n_cmp++;
        if (rk_w[31] !== RK0_A) begin
            n_fail++; $display("FAIL dec_rk_31: got %08h want %08h", rk_w[31], RK0_A);
        end
`else
        check_keys_a("dec_ignored");
`endif
        enc_dec_sel_in = 1'b0;
        #1;
        check_keys_a("enc_again");
    endtask

    task automatic test_ignore_valid();
        int lat;
        user_key_in = KEY_A; user_key_valid_in = 1'b1;
        tick();
        user_key_valid_in = 1'b0;
        lat = 1;
        n_cmp++;
        if (key_exp_ready_out !== 1'b0) begin
            n_fail++; $display("FAIL reexpand_drop: ready got %b want 0", key_exp_ready_out);
        end
        repeat (9) begin tick(); lat++; end
        user_key_in = 128'h0; user_key_valid_in = 1'b1;
        tick(); lat++;
        user_key_valid_in = 1'b0;
        while (!key_exp_ready_out && lat < 40) begin tick(); lat++; end
        n_cmp++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL ignore_latency: got %0d want 33", lat);
        end
        check_keys_a("ignore");
    endtask

    task automatic test_enable_drop();
        int lat, highs;
        user_key_in = KEY_A; user_key_valid_in = 1'b1;
        tick();
        user_key_valid_in = 1'b0;
        repeat (19) tick();
        sm4_enable_in = 1'b0;
        tick();
        n_cmp++;
        if (key_exp_ready_out !== 1'b0) begin
            n_fail++; $display("FAIL drop_ready: got %b want 0", key_exp_ready_out);
        end
        n_cmp++;
        if (rk_w[31] !== RK31_A) begin
            n_fail++; $display("FAIL drop_retain_rk31: got %08h want %08h", rk_w[31], RK31_A);
        end
        // valid while disabled must not start anything
        user_key_valid_in = 1'b1;
        repeat (3) tick();
        user_key_valid_in = 1'b0;
        sm4_enable_in = 1'b1;
        highs = 0;
        repeat (36) begin tick(); if (key_exp_ready_out !== 1'b0) highs++; end
        n_cmp++;
        if (highs !== 0) begin
            n_fail++; $display("FAIL drop_stay_idle: ready high %0d cycles want 0", highs);
        end
        run_expand(KEY_A, lat);
        n_cmp++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL drop_reexpand_latency: got %0d want 33", lat);
        end
        check_keys_a("drop");
    endtask

    task automatic test_reset_mid();
        int lat, nz, highs;
        user_key_in = KEY_A; user_key_valid_in = 1'b1;
        tick();
        user_key_valid_in = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nz = 0;
        for (int i = 0; i < 32; i++) if (rk_w[i] !== 32'h0) nz++;
        n_cmp++;
        if (key_exp_ready_out !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 0", key_exp_ready_out);
        end
        n_cmp++;
        if (nz !== 0) begin
            n_fail++; $display("FAIL rstmid_rk: %0d nonzero keys, want 0", nz);
        end
        highs = 0;
        repeat (36) begin tick(); if (key_exp_ready_out !== 1'b0) highs++; end
        n_cmp++;
        if (highs !== 0) begin
            n_fail++; $display("FAIL rstmid_no_ready: ready high %0d cycles want 0", highs);
        end
        run_expand(KEY_A, lat);
        n_cmp++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL rstmid_latency: got %0d want 33", lat);
        end
        check_keys_a("rstmid");
    endtask

    task automatic test_datapath();
        logic [31:0] x [36];
        logic [127:0] ct;
        enc_dec_sel_in = 1'b0;
        #1;
        x[0] = KEY_A[127:96]; x[1] = KEY_A[95:64]; x[2] = KEY_A[63:32]; x[3] = KEY_A[31:0];
        for (int i = 0; i < 32; i++)
            x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk_w[i]);
        ct = {x[35], x[34], x[33], x[32]};
        n_cmp++;
        if (ct !== CT_A) begin
            n_fail++; $display("FAIL datapath_ct: got %032h want %032h", ct, CT_A);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_dec_order();
        test_ignore_valid();
        test_enable_drop();
        test_reset_mid();
        test_datapath();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
